// File: rtl/tb_ctrl_mc_if.sv
// Bus bundle between the AHB bridge and the transceiver/buffer controller.
// Carries the transfer-qualifying inputs (ready, write flags, HTRANS, HSEL,
// grant) and the active-low enable outputs (MAPSn, MDPSn, SDPSn, SRSn, DENn)
// together with DIR, TURN_WAIT and CONFLICT.
//   master : the bridge side, drives the transfer inputs and sees the enables
//   slave  : the controller side, consumes the inputs and drives the enables
interface tb_ctrl_mc_if #(
    parameter int unsigned NUM_SLV = 2
);
    logic               HREADYin;
    logic               HWRITEin;
    logic               HWRITEout;
    logic [1:0]         HTRANSin;
    logic [NUM_SLV-1:0] HSEL;
    logic               HGRANT;
    logic               MAPSn;
    logic               MDPSn;
    logic [NUM_SLV-1:0] SDPSn;
    logic [NUM_SLV-1:0] SRSn;
    logic               DENn;
    logic               DIR;
    logic               TURN_WAIT;
    logic               CONFLICT;

    modport master (
        output HREADYin, HWRITEin, HWRITEout, HTRANSin, HSEL, HGRANT,
        input  MAPSn, MDPSn, SDPSn, SRSn, DENn, DIR, TURN_WAIT, CONFLICT
    );

    modport slave (
        input  HREADYin, HWRITEin, HWRITEout, HTRANSin, HSEL, HGRANT,
        output MAPSn, MDPSn, SDPSn, SRSn, DENn, DIR, TURN_WAIT, CONFLICT
    );
endinterface

// File: rtl/tb_ctrl_mc.sv
// Multi-channel transceiver/buffer control for the AHB bridge.
// Generates master address/data-phase enables and per-channel slave
// data-phase enables, tracks data-bus direction and inserts TURN_CYC dead
// cycles (TURN_WAIT high) whenever the bus direction reverses. CONFLICT is a
// sticky flag for overlapping master and slave data phases.
// Ports:
//   HCLK     clock, rising edge
//   HRESETn  asynchronous active-low reset
//   bus      tb_ctrl_mc_if.slave: HREADYin, HWRITEin, HWRITEout, HTRANSin,
//            HSEL, HGRANT in; MAPSn, MDPSn, SDPSn, SRSn, DENn, DIR,
//            TURN_WAIT, CONFLICT out
// Parameters: NUM_SLV (1..8), TURN_CYC (0..7, 0 = no turnaround).
// Build option: define TBCTRL_HTRANS_QUAL_EN to qualify slave data phases
// with HTRANSin[1]; undefined, HSEL alone starts a slave data phase.
module tb_ctrl_mc #(
    parameter int unsigned NUM_SLV  = 2,
    parameter int unsigned TURN_CYC = 1
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    tb_ctrl_mc_if.slave  bus
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_last_dir;
    logic               w_last_dir_nxt;

    logic               r_g_q;
    logic               r_m_dp;
    logic               r_m_wr;
    logic [NUM_SLV-1:0] r_s_dp;
    logic               r_s_rd;
    logic               r_conflict;

    logic               w_qual;
    logic [NUM_SLV-1:0] w_sel_low;
    logic               w_s_any;
    logic               w_overlap;
    logic               w_req_vld;
    logic               w_req_dir;
    logic               w_match;

    logic               w_en;
    logic               w_wait;
    logic               w_mdps_n;
    logic [NUM_SLV-1:0] w_sdps_n;
    logic [NUM_SLV-1:0] w_srs_n;
    logic               w_den_n;
    logic               w_dir;

    // HTRANSin bits not consumed in every build
    logic               w_unused_htrans;
    assign w_unused_htrans = ^bus.HTRANSin;

`ifdef TBCTRL_HTRANS_QUAL_EN
    assign w_qual = bus.HTRANSin[1];
`else
    assign w_qual = 1'b1;
`endif

    // Keep only the lowest-index set HSEL bit (x & -x)
    assign w_sel_low = bus.HSEL & (~bus.HSEL + NUM_SLV'(1));

    // Grant and data-phase capture
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_g_q      <= 1'b0;
            r_m_dp     <= 1'b0;
            r_m_wr     <= 1'b0;
            r_s_dp     <= '0;
            r_s_rd     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_g_q <= bus.HGRANT;
            if (bus.HREADYin) begin
                r_m_dp <= r_g_q;
                r_m_wr <= bus.HWRITEout;
                r_s_dp <= w_sel_low & {NUM_SLV{w_qual}};
                r_s_rd <= ~bus.HWRITEin;
            end
            if (w_overlap) begin
                r_conflict <= 1'b1;
            end
        end
    end

    // Requested direction; the master side wins when both phases overlap
    assign w_s_any   = |r_s_dp;
    assign w_overlap = r_m_dp & w_s_any;
    assign w_req_vld = r_m_dp | w_s_any;
    assign w_req_dir = r_m_dp ? r_m_wr : r_s_rd;
    assign w_match   = (w_req_dir == r_last_dir) || (TURN_CYC == 0);

    // FSM state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_last_dir <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last_dir <= w_last_dir_nxt;
        end
    end

    // FSM next state. The first wait cycle is spent in IDLE/DRIVE, so TURN
    // only covers wait cycles 2..TURN_CYC and r_cnt holds the ones left.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_last_dir_nxt = r_last_dir;
        case (r_state)
            ST_IDLE, ST_DRIVE: begin
                if (!w_req_vld) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_match || (TURN_CYC == 1)) begin
                    w_state_nxt    = ST_DRIVE;
                    w_last_dir_nxt = w_req_dir;
                end else begin
                    w_state_nxt = ST_TURN;
                    w_cnt_nxt   = CNT_W'(TURN_CYC - 1);
                end
            end
            ST_TURN: begin
                if (!w_req_vld) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt    = ST_DRIVE;
                    w_cnt_nxt      = '0;
                    w_last_dir_nxt = w_req_dir;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FSM outputs: enables only in a matching-direction cycle outside TURN
    always_comb begin
        w_en     = 1'b0;
        w_wait   = 1'b0;
        w_mdps_n = 1'b1;
        w_sdps_n = '1;
        w_srs_n  = '1;
        w_den_n  = 1'b1;
        w_dir    = r_last_dir;
        case (r_state)
            ST_IDLE, ST_DRIVE: begin
                w_en   = w_req_vld & w_match;
                w_wait = w_req_vld & ~w_match;
            end
            ST_TURN: begin
                w_wait = w_req_vld;
            end
            default: begin
                w_en   = 1'b0;
                w_wait = 1'b0;
            end
        endcase
        if (w_en) begin
            w_dir    = w_req_dir;
            w_mdps_n = ~(r_m_dp & r_m_wr);
            // Slave enables stay off while a master data phase is active
            w_srs_n  = ~(r_s_dp & {NUM_SLV{~r_m_dp}});
            w_sdps_n = ~(r_s_dp & {NUM_SLV{~r_m_dp & r_s_rd}});
        end
        w_den_n = w_mdps_n & (&w_sdps_n);
    end

    assign bus.MAPSn     = ~r_g_q;
    assign bus.MDPSn     = w_mdps_n;
    assign bus.SDPSn     = w_sdps_n;
    assign bus.SRSn      = w_srs_n;
    assign bus.DENn      = w_den_n;
    assign bus.DIR       = w_dir;
    assign bus.TURN_WAIT = w_wait;
    assign bus.CONFLICT  = r_conflict | w_overlap;

endmodule

// File: tb/tb_tb_ctrl_mc.sv
// Self-checking bench for tb_ctrl_mc. Two instances (TURN_CYC=1 and
// TURN_CYC=3) share stimulus; each is compared every cycle against a
// transaction-level reference model, plus directed scenario checks.
// Each instance's HREADYin is pulled low during its expected turnaround
// cycles, as the system does by ANDing ~TURN_WAIT into HREADYout.
module tb_tb_ctrl_mc;

    localparam int unsigned NUM_SLV = 2;

    typedef struct packed {
        logic       gnt;
        logic       wout;
        logic       win;
        logic [1:0] trans;
        logic [1:0] hsel;
        logic       ready;
    } stim_t;

    typedef struct packed {
        logic       maps_n;
        logic       mdps_n;
        logic [1:0] sdps_n;
        logic [1:0] srs_n;
        logic       den_n;
        logic       dir;
        logic       turn_wait;
        logic       conflict;
    } exp_t;

    // Reference model: captured transfers as channel index / flags
    typedef struct {
        bit gnt;
        bit m_vld;
        bit m_wr;
        int s_ch;
        bit s_rd;
        bit dir;
        int wait_left;
        bit err;
    } mdl_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    mdl_t mdl1;
    mdl_t mdl3;

    tb_ctrl_mc_if #(.NUM_SLV(NUM_SLV)) if1 ();
    tb_ctrl_mc_if #(.NUM_SLV(NUM_SLV)) if3 ();

    tb_ctrl_mc #(.NUM_SLV(NUM_SLV), .TURN_CYC(1)) u_dut1 (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (if1)
    );

    tb_ctrl_mc #(.NUM_SLV(NUM_SLV), .TURN_CYC(3)) u_dut3 (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.gnt = 0; m.m_vld = 0; m.m_wr = 0; m.s_ch = -1; m.s_rd = 0;
        m.dir = 0; m.wait_left = 0; m.err = 0;
        return m;
    endfunction

    // Expected outputs for the current model state; w = turnaround cycle
    function automatic void predict(input mdl_t m, input int tc, output exp_t e, output bit w);
        bit active;
        bit want;
        bit drive;
        active = m.m_vld || (m.s_ch >= 0);
        want   = m.m_vld ? m.m_wr : m.s_rd;
        w      = active && ((m.wait_left > 0) || ((want != m.dir) && (tc > 0)));
        drive  = active && !w;
        e.maps_n    = !m.gnt;
        e.mdps_n    = 1'b1;
        e.sdps_n    = 2'b11;
        e.srs_n     = 2'b11;
        e.dir       = drive ? want : m.dir;
        e.turn_wait = w;
        e.conflict  = m.err || (m.m_vld && (m.s_ch >= 0));
        if (drive) begin
            if (m.m_vld && m.m_wr) e.mdps_n = 1'b0;
            if (!m.m_vld && (m.s_ch >= 0)) begin
                e.srs_n[m.s_ch] = 1'b0;
                if (m.s_rd) e.sdps_n[m.s_ch] = 1'b0;
            end
        end
        e.den_n = e.mdps_n & (&e.sdps_n);
    endfunction

    // Model state after the coming clock edge
    function automatic mdl_t advance(input mdl_t m, input int tc, input stim_t s, input bit rdy);
        mdl_t n;
        bit   active;
        bit   want;
        bit   qual;
        n      = m;
        active = m.m_vld || (m.s_ch >= 0);
        want   = m.m_vld ? m.m_wr : m.s_rd;
        if (!active) begin
            n.wait_left = 0;
        end else begin
            if ((m.wait_left == 0) && (want != m.dir)) begin
                if (tc == 0) n.dir = want;
                else         n.wait_left = tc;
            end
            if (n.wait_left > 0) begin
                n.wait_left--;
                if (n.wait_left == 0) n.dir = want;
            end
        end
        if (m.m_vld && (m.s_ch >= 0)) n.err = 1'b1;
`ifdef TBCTRL_HTRANS_QUAL_EN
        qual = s.trans[1];
`else
        qual = 1'b1;
`endif
        n.gnt = s.gnt;
        if (rdy) begin
            n.m_vld = m.gnt;
            n.m_wr  = s.wout;
            n.s_rd  = !s.win;
            n.s_ch  = -1;
            if (qual) begin
                for (int i = NUM_SLV - 1; i >= 0; i--) begin
                    if (s.hsel[i]) n.s_ch = i;
                end
            end
        end
        return n;
    endfunction

    function automatic stim_t mk(input bit gnt, input bit wout, input bit win,
                                 input bit [1:0] trans, input bit [1:0] hsel, input bit ready);
        stim_t s;
        s.gnt = gnt; s.wout = wout; s.win = win; s.trans = trans; s.hsel = hsel; s.ready = ready;
        return s;
    endfunction

    task automatic compare_outs(input string tag, input exp_t act, input exp_t e);
        check_eq({tag, ".MAPSn"},     32'(act.maps_n),    32'(e.maps_n));
        check_eq({tag, ".MDPSn"},     32'(act.mdps_n),    32'(e.mdps_n));
        check_eq({tag, ".SDPSn"},     32'(act.sdps_n),    32'(e.sdps_n));
        check_eq({tag, ".SRSn"},      32'(act.srs_n),     32'(e.srs_n));
        check_eq({tag, ".DENn"},      32'(act.den_n),     32'(e.den_n));
        check_eq({tag, ".DIR"},       32'(act.dir),       32'(e.dir));
        check_eq({tag, ".TURN_WAIT"}, 32'(act.turn_wait), 32'(e.turn_wait));
        check_eq({tag, ".CONFLICT"},  32'(act.conflict),  32'(e.conflict));
    endtask

    function automatic exp_t act1();
        return {if1.MAPSn, if1.MDPSn, if1.SDPSn, if1.SRSn, if1.DENn, if1.DIR, if1.TURN_WAIT, if1.CONFLICT};
    endfunction

    function automatic exp_t act3();
        return {if3.MAPSn, if3.MDPSn, if3.SDPSn, if3.SRSn, if3.DENn, if3.DIR, if3.TURN_WAIT, if3.CONFLICT};
    endfunction

    task automatic check_both();
        exp_t e;
        bit   w;
        predict(mdl1, 1, e, w);
        compare_outs("dut1", act1(), e);
        predict(mdl3, 3, e, w);
        compare_outs("dut3", act3(), e);
    endtask

    task automatic drive(input stim_t s, input bit w1, input bit w3);
        if1.HGRANT = s.gnt;   if3.HGRANT = s.gnt;
        if1.HWRITEout = s.wout; if3.HWRITEout = s.wout;
        if1.HWRITEin = s.win; if3.HWRITEin = s.win;
        if1.HTRANSin = s.trans; if3.HTRANSin = s.trans;
        if1.HSEL = s.hsel;    if3.HSEL = s.hsel;
        if1.HREADYin = s.ready & ~w1;
        if3.HREADYin = s.ready & ~w3;
    endtask

    // One clock: drive at the falling edge, check at the next falling edge
    task automatic cycle(input stim_t s);
        exp_t e;
        bit   w1;
        bit   w3;
        predict(mdl1, 1, e, w1);
        predict(mdl3, 3, e, w3);
        drive(s, w1, w3);
        mdl1 = advance(mdl1, 1, s, s.ready && !w1);
        mdl3 = advance(mdl3, 3, s, s.ready && !w3);
        @(posedge clk);
        @(negedge clk);
        check_both();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(mk(0, 0, 0, 2'b00, 2'b00, 1));
    endtask

    localparam exp_t RST_EXP = '{maps_n: 1'b1, mdps_n: 1'b1, sdps_n: 2'b11, srs_n: 2'b11,
                                 den_n: 1'b1, dir: 1'b0, turn_wait: 1'b0, conflict: 1'b0};

    initial begin
        stim_t s;
        int    n1;
        int    n3;
        bit    prev_gnt;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        mdl1     = mdl_reset();
        mdl3     = mdl_reset();
        drive(mk(0, 0, 0, 2'b00, 2'b00, 1), 0, 0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_both();
        rst_n = 1'b1;

        // First turnaround: slave read on channel 1
        idle(2);
        cycle(mk(0, 0, 0, 2'b10, 2'b10, 1));
        check_eq("turn1.wait",  32'(if1.TURN_WAIT), 32'd1);
        check_eq("turn1.sdps",  32'(if1.SDPSn),     32'b11);
        cycle(mk(0, 0, 0, 2'b00, 2'b00, 1));
        check_eq("turn1.wait_off", 32'(if1.TURN_WAIT), 32'd0);
        check_eq("turn1.dir",   32'(if1.DIR),   32'd1);
        check_eq("turn1.sdps_on", 32'(if1.SDPSn), 32'b01);
        check_eq("turn1.srs_on",  32'(if1.SRSn),  32'b01);
        check_eq("turn1.den",   32'(if1.DENn),  32'd0);

        // Back-to-back reads then a write
        cycle(mk(0, 0, 0, 2'b10, 2'b01, 1));
        check_eq("b2b.rd1_wait", 32'(if1.TURN_WAIT), 32'd0);
        cycle(mk(0, 0, 0, 2'b10, 2'b01, 1));
        check_eq("b2b.rd2_wait", 32'(if1.TURN_WAIT), 32'd0);
        cycle(mk(0, 0, 1, 2'b10, 2'b01, 1));
        check_eq("b2b.wr_wait", 32'(if1.TURN_WAIT), 32'd1);
        cycle(mk(0, 0, 0, 2'b00, 2'b00, 1));
        check_eq("b2b.wr_dir",  32'(if1.DIR),   32'd0);
        check_eq("b2b.wr_srs",  32'(if1.SRSn),  32'b10);
        check_eq("b2b.wr_sdps", 32'(if1.SDPSn), 32'b11);
        idle(6);

        // Master write held by wait states
        cycle(mk(1, 0, 0, 2'b00, 2'b00, 1));
        cycle(mk(0, 1, 0, 2'b00, 2'b00, 1));
        cycle(mk(0, 0, 0, 2'b00, 2'b00, 0));
        check_eq("mwr.mdps", 32'(if1.MDPSn), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(mk(0, 0, 0, 2'b00, 2'b00, 0));
            check_eq($sformatf("hold%0d.mdps", i), 32'(if1.MDPSn), 32'd0);
            check_eq($sformatf("hold%0d.den", i),  32'(if1.DENn),  32'd0);
        end
        idle(6);

        // Overlapping master and slave data phases
        cycle(mk(1, 1, 0, 2'b00, 2'b00, 1));
        cycle(mk(0, 1, 0, 2'b10, 2'b01, 1));
        check_eq("conf.flag", 32'(if1.CONFLICT), 32'd1);
        check_eq("conf.srs",  32'(if1.SRSn),     32'b11);
        check_eq("conf.sdps", 32'(if1.SDPSn),    32'b11);
        idle(2);
        check_eq("conf.sticky", 32'(if1.CONFLICT), 32'd1);
        idle(4);

        // Asynchronous reset in the middle of a turnaround
        cycle(mk(0, 0, 1, 2'b10, 2'b01, 1));
        check_eq("rst.pre_wait", 32'(if1.TURN_WAIT), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        compare_outs("rst_async1", act1(), RST_EXP);
        compare_outs("rst_async3", act3(), RST_EXP);
        drive(mk(0, 0, 0, 2'b00, 2'b00, 1), 0, 0);
        mdl1 = mdl_reset();
        mdl3 = mdl_reset();
        @(negedge clk);
        check_both();
        rst_n = 1'b1;

        // TURN_CYC=3: in->out, then out->in counted
        cycle(mk(0, 0, 0, 2'b10, 2'b10, 1));
        idle(6);
        cycle(mk(0, 0, 1, 2'b10, 2'b01, 1));
        n1 = int'(if1.TURN_WAIT);
        n3 = int'(if3.TURN_WAIT);
        for (int i = 0; i < 8; i++) begin
            cycle(mk(0, 0, 0, 2'b00, 2'b00, 1));
            n1 += int'(if1.TURN_WAIT);
            n3 += int'(if3.TURN_WAIT);
        end
        check_eq("tc3.wait_cycles", 32'(n3), 32'd3);
        check_eq("tc1.wait_cycles", 32'(n1), 32'd1);

        // Transfer qualification: IDLE HTRANS with HSEL set
        cycle(mk(0, 0, 1, 2'b00, 2'b01, 1));
`ifdef TBCTRL_HTRANS_QUAL_EN
        check_eq("qual.srs0", 32'(if1.SRSn[0]), 32'd1);
`else
        check_eq("qual.srs0", 32'(if1.SRSn[0]), 32'd0);
`endif
        cycle(mk(0, 0, 0, 2'b00, 2'b00, 1));
        check_eq("qual.srs_after", 32'(if1.SRSn), 32'b11);

        // Randomized traffic, master and slave phases kept apart
        prev_gnt = 1'b0;
        for (int c = 0; c < 400; c++) begin
            s.gnt   = ($urandom_range(0, 3) == 0);
            s.wout  = 1'($urandom);
            s.win   = 1'($urandom);
            s.trans = 2'($urandom);
            s.hsel  = prev_gnt ? 2'b00 : 2'($urandom);
            s.ready = ($urandom_range(0, 3) != 0);
            prev_gnt = s.gnt;
            cycle(s);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
